// File: rtl/ram2raccoon_if.sv
// Host-side request/response port of the ram2raccoon ring initiator.
// Single outstanding request; REQ is ignored while BUSY.
interface ram2raccoon_if;
  logic        REQ;
  logic        WE;
  logic [19:0] ADDR;
  logic [3:0]  MASK;
  logic [31:0] WR_DATA;
  logic        BUSY;
  logic        ACK;
  logic        ERR;
  logic [31:0] RD_DATA;

  modport master (
    output REQ, WE, ADDR, MASK, WR_DATA,
    input  BUSY, ACK, ERR, RD_DATA
  );

  modport slave (
    input  REQ, WE, ADDR, MASK, WR_DATA,
    output BUSY, ACK, ERR, RD_DATA
  );
endinterface

// File: rtl/ram2raccoon.sv
// Raccoon ring initiator: inserts one host request into a free ring slot,
// forwards foreign traffic and consumes its own response or returned request.
module ram2raccoon #(
  parameter logic [3:0]  RACC_ID = 4'd0,
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [63:0]   RaccIn,
  output logic [63:0]   RaccOut,
  ram2raccoon_if.slave  host
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [19:0] addr_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt, cnt_nxt;
  logic [63:0] racc_nxt;
  logic [31:0] rd_q, rd_nxt;
  logic        err_q, err_nxt;
  logic        capture;

  logic in_valid, in_resp, in_own;
  assign in_valid = RaccIn[63];
  assign in_resp  = RaccIn[62];
  assign in_own   = in_valid && (RaccIn[55:52] == RACC_ID);

  always_comb begin
    state_nxt = state;
    racc_nxt  = RaccIn;
    cnt_nxt   = cnt;
    rd_nxt    = rd_q;
    err_nxt   = err_q;
    capture   = 1'b0;
    unique case (state)
      // DONE behaves as IDLE so a request can be taken in the ACK cycle
      IDLE, DONE: begin
        if (in_own) racc_nxt = '0;
        if (host.REQ) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        // a stray own packet is overwritten as if the slot were empty
        if (!in_valid || in_own) begin
          racc_nxt  = {1'b1, 1'b0, we_q, 1'b0, mask_q, RACC_ID, addr_q, wdata_q};
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + 16'd1;
        if (in_own) begin
          racc_nxt  = '0;
          rd_nxt    = in_resp ? RaccIn[31:0] : '0;
          err_nxt   = !in_resp;
          state_nxt = DONE;
        end else if (cnt == TIMEOUT) begin
          rd_nxt    = '0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      RaccOut <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      RaccOut <= racc_nxt;
      rd_q    <= rd_nxt;
      err_q   <= err_nxt;
      if (capture) begin
        we_q    <= host.WE;
        addr_q  <= host.ADDR;
        mask_q  <= host.MASK;
        wdata_q <= host.WR_DATA;
      end
    end
  end

  assign host.BUSY    = (state == SEND) || (state == WAIT);
  assign host.ACK     = (state == DONE);
  assign host.ERR     = err_q;
  assign host.RD_DATA = rd_q;

endmodule

// File: tb/tb_ram2raccoon.sv
// Bench for ram2raccoon: 4-node ring (DUT, plain hop, SRAM responder at
// 0x10000, foreign-traffic injector) with a word-array memory reference.
module tb_ram2raccoon;
  localparam logic [3:0] ID  = 4'd3;
  localparam logic [3:0] FID = 4'd5;
  localparam int         TMO = 20;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] racc_in, racc_out;
  int          cyc = 0;
  int unsigned n_cmp = 0, n_bad = 0;

  ram2raccoon_if host();

  ram2raccoon #(.RACC_ID(ID), .TIMEOUT(16'(TMO))) dut (
    .CLK(CLK), .RST(RST), .RaccIn(racc_in), .RaccOut(racc_out), .host(host)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'hCAFEF00D;
    if (i == 2) return 32'hFFFFFFFF;
    return 32'h5A000000 | (32'(i) * 32'h00010203);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- ring model ----------------
  logic        ring_clr, inj_en;
  int          stall;
  logic [63:0] n1_q, n2_q, inj_pkt;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pend, pend_nxt;
  logic [63:0] pend_pkt, pend_pkt_nxt, s_out, i_out, rsp;
  int          pend_cnt, pend_cnt_nxt;
  logic        mem_we;
  logic [5:0]  mem_idx;
  logic [31:0] mem_wd, rsp_word;

  always_comb begin
    s_out        = n1_q;
    pend_nxt     = pend;
    pend_pkt_nxt = pend_pkt;
    pend_cnt_nxt = (pend && pend_cnt > 0) ? pend_cnt - 1 : pend_cnt;
    mem_idx      = n1_q[39:34];
    mem_wd       = merge(mem[mem_idx], n1_q[31:0], n1_q[59:56]);
    mem_we       = 1'b0;
    rsp_word     = mem[mem_idx];
    rsp          = '0;
    if (n1_q[63] && !n1_q[62] && n1_q[51:40] == 12'h100) begin
      mem_we   = n1_q[61];
      rsp_word = n1_q[61] ? mem_wd : mem[mem_idx];
      rsp      = {2'b11, n1_q[61:32], rsp_word};
      if (stall != 0) begin
        s_out        = '0;
        pend_nxt     = 1'b1;
        pend_pkt_nxt = rsp;
        pend_cnt_nxt = stall;
      end else begin
        s_out = rsp;
      end
    end else if (pend && pend_cnt == 0 && !n1_q[63]) begin
      s_out    = pend_pkt;
      pend_nxt = 1'b0;
    end
  end

  always_comb begin
    i_out = n2_q;
    if (n2_q[63] && n2_q[55:52] == FID) i_out = '0;
    if (inj_en && !i_out[63]) i_out = inj_pkt;
  end

  always @(posedge CLK) begin
    inj_pkt <= {1'b1, 1'($urandom), 1'($urandom), 1'b0, 4'($urandom), FID, 4'h8, 16'($urandom), 32'($urandom)};
    if (ring_clr) begin
      n1_q <= '0; n2_q <= '0; racc_in <= '0;
      pend <= 1'b0; pend_pkt <= '0; pend_cnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else begin
      n1_q     <= racc_out;
      n2_q     <= s_out;
      racc_in  <= i_out;
      pend     <= pend_nxt;
      pend_pkt <= pend_pkt_nxt;
      pend_cnt <= pend_cnt_nxt;
      if (mem_we) mem[mem_idx] <= mem_wd;
    end
  end

  // ---------------- host driver ----------------
  task automatic run_txn(input logic we, input logic [19:0] addr, input logic [3:0] mask,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int acks, output int entry_to_ack);
    int t_ack, t_entry;
    @(negedge CLK);
    host.REQ = 1'b1; host.WE = we; host.ADDR = addr; host.MASK = mask; host.WR_DATA = wd;
    @(negedge CLK);
    host.REQ = 1'b0;
    t_ack = -1; t_entry = -1; acks = 0; rd = '0; err = 1'b0;
    for (int i = 0; i < 200 && t_ack < 0; i++) begin
      if (t_entry < 0 && racc_out[63] && !racc_out[62] && racc_out[55:52] == ID) t_entry = cyc;
      if (host.ACK) begin t_ack = cyc; acks++; rd = host.RD_DATA; err = host.ERR; end
      if (t_ack < 0) @(negedge CLK);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (host.ACK) acks++;
    end
    entry_to_ack = (t_ack >= 0 && t_entry >= 0) ? t_ack - t_entry : -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RST = 1'b0; ring_clr = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if (racc_out !== 64'h0) begin n_bad++; $display("FAIL reset_raccout: got %h expected 0", racc_out); end
    n_cmp++; if (host.ACK !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", host.ACK); end
    n_cmp++; if (host.ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", host.ERR); end
    n_cmp++; if (host.RD_DATA !== 32'h0) begin n_bad++; $display("FAIL reset_rddata: got %h expected 0", host.RD_DATA); end
    n_cmp++; if (host.BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", host.BUSY); end
    RST = 1'b1; ring_clr = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_read;
    logic [31:0] wd;
    logic [63:0] exp_req;
    int k;
    wd = $urandom;
    @(negedge CLK);
    host.REQ = 1'b1; host.WE = 1'b0; host.ADDR = 20'h10004; host.MASK = 4'hF; host.WR_DATA = wd;
    @(negedge CLK);
    host.REQ = 1'b0;
    n_cmp++; if (host.BUSY !== 1'b1) begin n_bad++; $display("FAIL read_busy_n1: got %b expected 1", host.BUSY); end
    @(negedge CLK);
    exp_req = {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, ID, 20'h10004, wd};
    n_cmp++; if (racc_out !== exp_req) begin n_bad++; $display("FAIL read_insert_n2: got %h expected %h", racc_out, exp_req); end
    k = 0;
    while (!(racc_in[63] && racc_in[55:52] == ID) && k < 50) begin @(negedge CLK); k++; end
    n_cmp++; if (k >= 50) begin n_bad++; $display("FAIL read_resp_wait: got %0d cycles expected <50", k); end
    @(negedge CLK);
    n_cmp++; if (host.ACK !== 1'b1) begin n_bad++; $display("FAIL read_ack_k1: got %b expected 1", host.ACK); end
    n_cmp++; if (host.ERR !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b expected 0", host.ERR); end
    n_cmp++; if (host.RD_DATA !== ref_mem[1]) begin n_bad++; $display("FAIL read_data: got %h expected %h", host.RD_DATA, ref_mem[1]); end
    n_cmp++; if (racc_out !== 64'h0) begin n_bad++; $display("FAIL read_consumed: got %h expected 0", racc_out); end
    @(negedge CLK);
    n_cmp++; if (host.ACK !== 1'b0) begin n_bad++; $display("FAIL read_single_ack: got %b expected 0", host.ACK); end
  endtask

  task automatic test_reset_mid_wait;
    int k, acks, own_out;
    logic [31:0] rd; logic err; int a, e2a;
    logic [5:0] idx;
    stall = 15;
    @(negedge CLK);
    host.REQ = 1'b1; host.WE = 1'b0; host.ADDR = 20'h10010; host.MASK = 4'hF; host.WR_DATA = '0;
    @(negedge CLK);
    host.REQ = 1'b0;
    k = 0;
    while (!(racc_out[63] && racc_out[55:52] == ID) && k < 50) begin @(negedge CLK); k++; end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    n_cmp++; if (racc_out !== 64'h0) begin n_bad++; $display("FAIL rstw_raccout: got %h expected 0", racc_out); end
    n_cmp++; if (host.ACK !== 1'b0) begin n_bad++; $display("FAIL rstw_ack: got %b expected 0", host.ACK); end
    n_cmp++; if (host.BUSY !== 1'b0) begin n_bad++; $display("FAIL rstw_busy: got %b expected 0", host.BUSY); end
    n_cmp++; if (host.RD_DATA !== 32'h0) begin n_bad++; $display("FAIL rstw_rddata: got %h expected 0", host.RD_DATA); end
    acks = 0; own_out = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (host.ACK) acks++;
      if (racc_out[63] && racc_out[55:52] == ID) own_out++;
    end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL rstw_no_ack: got %0d acks expected 0", acks); end
    n_cmp++; if (own_out != 0) begin n_bad++; $display("FAIL rstw_stale_dropped: got %0d own packets out expected 0", own_out); end
    k = 0;
    while (pend && k < 100) begin @(negedge CLK); k++; end
    repeat (5) @(negedge CLK);
    stall = 0;
    idx = 6'($urandom_range(0, 63));
    run_txn(1'b0, 20'h10000 | {12'h0, idx, 2'b00}, 4'hF, '0, rd, err, a, e2a);
    n_cmp++; if (rd !== ref_mem[idx] || err !== 1'b0 || a != 1) begin
      n_bad++; $display("FAIL rstw_next_read: got data %h err %b acks %0d expected %h 0 1", rd, err, a, ref_mem[idx]);
    end
  endtask

  task automatic test_masked_write;
    logic [31:0] rd; logic err; int a, e2a;
    run_txn(1'b1, 20'h10008, 4'b0101, 32'h11223344, rd, err, a, e2a);
    ref_mem[2] = merge(ref_mem[2], 32'h11223344, 4'b0101);
    n_cmp++; if (rd !== 32'hFF22FF44) begin n_bad++; $display("FAIL mwrite_resp: got %h expected ff22ff44", rd); end
    n_cmp++; if (err !== 1'b0 || a != 1) begin n_bad++; $display("FAIL mwrite_ack: got err %b acks %0d expected 0 1", err, a); end
    run_txn(1'b0, 20'h10008, 4'hF, '0, rd, err, a, e2a);
    n_cmp++; if (rd !== 32'hFF22FF44) begin n_bad++; $display("FAIL mwrite_readback: got %h expected ff22ff44", rd); end
    n_cmp++; if (err !== 1'b0 || a != 1) begin n_bad++; $display("FAIL mwrite_rb_ack: got err %b acks %0d expected 0 1", err, a); end
  endtask

  task automatic test_unclaimed;
    logic [31:0] rd; logic err; int a, e2a;
    run_txn(1'b0, 20'h90000, 4'hF, 32'h12345678, rd, err, a, e2a);
    n_cmp++; if (err !== 1'b1 || a != 1) begin n_bad++; $display("FAIL unclaimed_err: got err %b acks %0d expected 1 1", err, a); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unclaimed_data: got %h expected 0", rd); end
    n_cmp++; if (e2a != 4) begin n_bad++; $display("FAIL unclaimed_latency: got %0d expected 4", e2a); end
  endtask

  task automatic test_occupied;
    logic [63:0] prev_in;
    int k, bad_fwd, not_busy;
    @(negedge CLK); inj_en = 1'b1;
    @(negedge CLK);
    host.REQ = 1'b1; host.WE = 1'b0; host.ADDR = 20'h10004; host.MASK = 4'hF; host.WR_DATA = '0;
    prev_in = racc_in;
    @(negedge CLK);
    host.REQ = 1'b0;
    bad_fwd = 0; not_busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(prev_in[63] && prev_in[55:52] == FID) || racc_out !== prev_in) bad_fwd++;
      if (host.BUSY !== 1'b1) not_busy++;
      prev_in = racc_in;
      @(negedge CLK);
    end
    inj_en = 1'b0;
    n_cmp++; if (bad_fwd != 0) begin n_bad++; $display("FAIL occupied_forward: got %0d altered slots expected 0", bad_fwd); end
    n_cmp++; if (not_busy != 0) begin n_bad++; $display("FAIL occupied_busy: got %0d idle cycles expected 0", not_busy); end
    k = 0;
    while (!host.ACK && k < 100) begin @(negedge CLK); k++; end
    n_cmp++; if (host.ACK !== 1'b1 || host.ERR !== 1'b0 || host.RD_DATA !== ref_mem[1]) begin
      n_bad++; $display("FAIL occupied_read: got ack %b err %b data %h expected 1 0 %h", host.ACK, host.ERR, host.RD_DATA, ref_mem[1]);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [5:0] ia, ib; logic [3:0] m; logic [31:0] d, exp_w; int k;
    ia = 6'($urandom_range(3, 63)); ib = 6'($urandom_range(3, 63));
    m = 4'($urandom); d = $urandom;
    @(negedge CLK);
    host.REQ = 1'b1; host.WE = 1'b0; host.ADDR = 20'h10000 | {12'h0, ia, 2'b00}; host.MASK = 4'hF;
    @(negedge CLK);
    host.REQ = 1'b0;
    k = 0;
    while (!host.ACK && k < 100) begin @(negedge CLK); k++; end
    n_cmp++; if (host.ACK !== 1'b1 || host.RD_DATA !== ref_mem[ia]) begin
      n_bad++; $display("FAIL b2b_first: got ack %b data %h expected 1 %h", host.ACK, host.RD_DATA, ref_mem[ia]);
    end
    host.REQ = 1'b1; host.WE = 1'b1; host.ADDR = 20'h10000 | {12'h0, ib, 2'b00}; host.MASK = m; host.WR_DATA = d;
    @(negedge CLK);
    host.REQ = 1'b0;
    n_cmp++; if (host.BUSY !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy %b expected 1", host.BUSY); end
    exp_w = merge(ref_mem[ib], d, m);
    ref_mem[ib] = exp_w;
    k = 0;
    while (!host.ACK && k < 100) begin @(negedge CLK); k++; end
    n_cmp++; if (host.ACK !== 1'b1 || host.ERR !== 1'b0 || host.RD_DATA !== exp_w) begin
      n_bad++; $display("FAIL b2b_second: got ack %b err %b data %h expected 1 0 %h", host.ACK, host.ERR, host.RD_DATA, exp_w);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_timeout;
    logic [31:0] rd; logic err; int a, e2a, acks, seen;
    logic [63:0] prev_in;
    stall = 50;
    run_txn(1'b0, 20'h10004, 4'hF, '0, rd, err, a, e2a);
    stall = 0;
    n_cmp++; if (err !== 1'b1 || rd !== 32'h0 || a != 1) begin
      n_bad++; $display("FAIL timeout_err: got err %b data %h acks %0d expected 1 0 1", err, rd, a);
    end
    n_cmp++; if (e2a != TMO + 1) begin n_bad++; $display("FAIL timeout_latency: got %0d expected %0d", e2a, TMO + 1); end
    acks = 0; seen = 0;
    prev_in = racc_in;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (prev_in[63] && prev_in[55:52] == ID) begin
        seen++;
        n_cmp++; if (racc_out !== 64'h0) begin n_bad++; $display("FAIL timeout_stray_drop: got %h expected 0", racc_out); end
      end
      if (host.ACK) acks++;
      prev_in = racc_in;
    end
    n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL timeout_late_resp_seen: got %0d expected 1", seen); end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL timeout_no_extra_ack: got %0d expected 0", acks); end
  endtask

  task automatic test_random;
    logic [31:0] rd, exp_d, d; logic err, exp_e, we; int a, e2a;
    logic [5:0] idx; logic [3:0] m; logic [19:0] addr; logic unc;
    for (int t = 0; t < 16; t++) begin
      unc = ($urandom_range(0, 4) == 0);
      we = 1'($urandom); m = 4'($urandom); d = $urandom; idx = 6'($urandom);
      addr = unc ? {4'h2, 16'($urandom)} : (20'h10000 | {12'h0, idx, 2'b00});
      if (unc) begin
        exp_d = 32'h0; exp_e = 1'b1;
      end else if (we) begin
        exp_d = merge(ref_mem[idx], d, m); ref_mem[idx] = exp_d; exp_e = 1'b0;
      end else begin
        exp_d = ref_mem[idx]; exp_e = 1'b0;
      end
      run_txn(we, addr, m, d, rd, err, a, e2a);
      n_cmp++; if (rd !== exp_d) begin n_bad++; $display("FAIL rand_data[%0d]: got %h expected %h", t, rd, exp_d); end
      n_cmp++; if (err !== exp_e) begin n_bad++; $display("FAIL rand_err[%0d]: got %b expected %b", t, err, exp_e); end
      n_cmp++; if (a != 1) begin n_bad++; $display("FAIL rand_acks[%0d]: got %0d expected 1", t, a); end
    end
  endtask

  initial begin
    RST = 1'b0; ring_clr = 1'b1; inj_en = 1'b0; stall = 0;
    host.REQ = 1'b0; host.WE = 1'b0; host.ADDR = '0; host.MASK = '0; host.WR_DATA = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    test_reset;
    test_read;
    test_reset_mid_wait;
    test_masked_write;
    test_unclaimed;
    test_occupied;
    test_back_to_back;
    test_timeout;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram2raccoon.md
# ram2raccoon

Initiator bridge that turns a simple single-outstanding memory request port into transactions on the 64-bit Raccoon ring bus, and collects the matching response. It is the master-side counterpart of the RAM-style responder nodes (e.g. shared SRAM): a CPU or DMA engine drives the host port, the block inserts a request into a free ring slot, forwards foreign traffic, and consumes its own response.

## Interface
- RACC_ID, 4'd0: initiator ID carried in every packet this node issues; must be unique on the ring.
- TIMEOUT, 16'd1023: maximum number of cycles in WAIT before the request is failed with ERR.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- RaccIn  in  64  ring input from the upstream node.
- RaccOut  out  64  ring output to the downstream node, registered.
- REQ  in  1  host request strobe.
- WE  in  1  1 = write, 0 = read; sampled with REQ.
- ADDR  in  20  byte address; sampled with REQ.
- MASK  in  4  byte-lane enables; bit n covers DATA[8n+7:8n]; sampled with REQ.
- WR_DATA  in  32  write data; sampled with REQ.
- BUSY  out  1  transaction in progress; REQ is ignored while high.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  qualifies ACK: request unclaimed or timed out.
- RD_DATA  out  32  response data, valid while ACK is high; held until the next completion.

## Operation
- Packet format: [63] VALID, [62] RESP (0 request, 1 response), [61] WE, [60] reserved 0, [59:56] MASK, [55:52] ID, [51:32] ADDR, [31:0] DATA. Empty slot = VALID 0, all other bits 0.
- "Own packet" = VALID && ID == RACC_ID.
- Forwarding: unless stated otherwise, RaccOut <= RaccIn each cycle (one-cycle hop).
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE: REQ sampled high -> capture WE/ADDR/MASK/WR_DATA, go to SEND. Any own packet arriving is stray: consume (RaccOut <= 0).
- SEND: if RaccIn is an empty slot or an own packet (stray, treated as empty), drive RaccOut <= {1, 0, WE, 0, MASK, RACC_ID, ADDR, WR_DATA}, clear the timeout counter, go to WAIT. Otherwise forward and stay in SEND. SEND never times out.
- WAIT: the counter increments every cycle.
  - Own response (RESP 1): consume, RD_DATA <= DATA, ERR <= 0, go to DONE.
  - Own request returned (RESP 0; no responder claimed it): consume, RD_DATA <= 32'h0, ERR <= 1, go to DONE.
  - Counter reaches TIMEOUT: RD_DATA <= 0, ERR <= 1, go to DONE. A late response is then dropped under the IDLE/SEND stray rules.
  - Own packet arriving in the same cycle as the timeout: the packet takes priority.
  - Foreign packets are always forwarded. No insertion happens in WAIT.
- DONE: ACK = 1 for exactly this cycle, BUSY = 0, go to IDLE. A REQ in this cycle is accepted, exactly as in IDLE.
- Writes complete only on a response. The responder's DATA is copied to RD_DATA for writes as well.
- The block never modifies foreign packets.

## Timing
- Reset values: RaccOut 64'h0, ACK 0, ERR 0, RD_DATA 32'h0, BUSY 0, state IDLE, counter 0.
- Reset mid-transaction: abort immediately, with no ACK. Packets already on the ring are removed later under the stray rules.
- BUSY = (state == SEND || state == WAIT), decoded from state registers.
- REQ sampled at edge N: BUSY high from cycle N+1, and the earliest insertion is at edge N+1 (RaccOut valid in cycle N+2).
- An own response present on RaccIn in cycle K produces ACK and RD_DATA in cycle K+1.
- Minimum host-to-ACK latency: 3 cycles plus ring round trip.
- Back-to-back: the next request can be sampled in the ACK cycle.
- Timeout: ERR ACK occurs TIMEOUT+1 cycles after entering WAIT, if no own packet is returned.

## Test plan
- Read round trip: 4-node ring with an SRAM model at base 0x10000 preloaded with 0xCAFEF00D at 0x10004. REQ read ADDR 0x10004 -> single ACK, ERR 0, RD_DATA 0xCAFEF00D, RaccOut empty in the cycle after consumption.
- Masked write: write 0x11223344 with MASK 4'b0101 over 0xFFFFFFFF at 0x10008, then read it back -> 0xFF22FF44, two ACKs, no ERR.
- Unclaimed address: read ADDR 0x90000 with no responder mapped -> the request circulates back, ACK with ERR 1, RD_DATA 0.
- Occupied ring: a foreign packet (ID 5) is injected into every slot for 10 cycles while in SEND -> insertion waits for the first empty slot, and all foreign packets come out bit-identical one cycle later.
- Timeout and stray drop: TIMEOUT=20, responder stalls for 50 cycles -> ERR ACK 21 cycles after WAIT entry. The late response is consumed in IDLE and does not appear on RaccOut.
- Reset mid-WAIT: assert RST low for 1 cycle -> all outputs at reset values, no ACK. The stale response is dropped, and the next read completes normally.
